// File: rtl/axi_write_packetizer.sv
// Converts an AXI4 write burst (AW + W) into one AXI-Stream packet: a routing
// header flit followed by one data flit per W beat, tlast derived from awlen.
module axi_write_packetizer #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDR_WIDTH    = 16,
   parameter int unsigned ID_WIDTH      = 4,
   parameter int unsigned MAX_ROUTERS_X = 4,
   parameter int unsigned MAX_ROUTERS_Y = 4,
   parameter int unsigned ROUTER_X      = 0,
   parameter int unsigned ROUTER_Y      = 0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,

   input  logic                  awvalid_i,
   output logic                  awready_o,
   input  logic [ADDR_WIDTH-1:0] awaddr_i,
   input  logic [ID_WIDTH-1:0]   awid_i,
   input  logic [7:0]            awlen_i,

   input  logic                  wvalid_i,
   output logic                  wready_o,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  wlast_i,

   output logic                  m_tvalid_o,
   input  logic                  m_tready_i,
   output logic [DATA_WIDTH-1:0] m_tdata_o,
   output logic                  m_tlast_o,
   output logic [ID_WIDTH-1:0]   m_tid_o,

   output logic                  len_err_o,
   output logic [15:0]           pkt_count_o
);

   localparam int unsigned X_W   = (MAX_ROUTERS_X > 1) ? $clog2(MAX_ROUTERS_X) : 1;
   localparam int unsigned Y_W   = (MAX_ROUTERS_Y > 1) ? $clog2(MAX_ROUTERS_Y) : 1;
   localparam int unsigned HDR_W = 2 * X_W + 2 * Y_W + ID_WIDTH + 8;

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StHeader = 2'd1;
   localparam logic [1:0] StData   = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [DATA_WIDTH-1:0] hdr_q, hdr_next;
   logic [ID_WIDTH-1:0]   id_q;
   logic [7:0]            len_q;
   logic [7:0]            cnt_q;
   logic                  len_err_q;
   logic [15:0]           pkt_count_q;

   logic [X_W-1:0]        target_x;
   logic [Y_W-1:0]        target_y;
   logic [HDR_W-1:0]      hdr_fields;
   logic                  aw_hs;
   logic                  hdr_hs;
   logic                  data_hs;
   logic                  last_beat;
   logic                  unused_addr;

   assign target_x    = awaddr_i[ADDR_WIDTH-1 -: X_W];
   assign target_y    = awaddr_i[ADDR_WIDTH-1-X_W -: Y_W];
   assign unused_addr = ^awaddr_i[ADDR_WIDTH-1-X_W-Y_W:0];

   assign hdr_fields = {awlen_i, awid_i, Y_W'(ROUTER_Y), X_W'(ROUTER_X), target_y, target_x};

   always_comb begin
      hdr_next              = '0;
      hdr_next[HDR_W-1:0]   = hdr_fields;
   end

   assign last_beat = (cnt_q == len_q);
   assign aw_hs     = awvalid_i && awready_o;
   assign hdr_hs    = (state_q == StHeader) && m_tready_i;
   assign data_hs   = (state_q == StData) && wvalid_i && m_tready_i;

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:   if (aw_hs) state_d = StHeader;
         StHeader: if (hdr_hs) state_d = StData;
         StData:   if (data_hs && last_beat) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         hdr_q       <= '0;
         id_q        <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         len_err_q   <= 1'b0;
         pkt_count_q <= '0;
      end else begin
         state_q <= state_d;
         if (aw_hs) begin
            hdr_q <= hdr_next;
            id_q  <= awid_i;
            len_q <= awlen_i;
         end
         // Wrap of cnt_q after the len=255 final beat is harmless: state leaves DATA.
         if (hdr_hs) begin
            cnt_q <= '0;
         end else if (data_hs) begin
            cnt_q <= cnt_q + 8'd1;
         end
         len_err_q <= data_hs && (wlast_i != last_beat);
         if (data_hs && last_beat) begin
            pkt_count_q <= pkt_count_q + 16'd1;
         end
      end
   end

   // Header comes from registers; data flits are a combinational W pass-through.
   always_comb begin
      awready_o  = (state_q == StIdle) && !rst_i;
      wready_o   = 1'b0;
      m_tvalid_o = 1'b0;
      m_tdata_o  = '0;
      m_tlast_o  = 1'b0;
      case (state_q)
         StHeader: begin
            m_tvalid_o = 1'b1;
            m_tdata_o  = hdr_q;
         end
         StData: begin
            m_tvalid_o = wvalid_i;
            wready_o   = m_tready_i;
            m_tdata_o  = wdata_i;
            m_tlast_o  = last_beat;
         end
         default: ;
      endcase
   end

   assign m_tid_o     = id_q;
   assign len_err_o   = len_err_q;
   assign pkt_count_o = pkt_count_q;

endmodule

// File: tb/tb_axi_write_packetizer.sv
// Bench for axi_write_packetizer: table-driven bursts, randomized bursts against a
// packet-level reference model, and hand-written reset sequences.
module tb_axi_write_packetizer;

   localparam int unsigned RX = 0;
   localparam int unsigned RY = 0;

   typedef struct {
      logic [15:0] addr;
      logic [3:0]  id;
      int          len;
      int          tr_mode;   // 0 always ready, 1 toggling from 0, 2 random
      int          wv_mode;   // 0 wvalid always, 1 random with hold
      int          err_beat;  // extra beat carrying wlast, -1 for none
      int          dmode;     // 0 random, 1 counting from 1, 2 first beat DEADBEEF
      logic [31:0] hdr;
      int          exp_err;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [15:0] awaddr = '0;
   logic [3:0]  awid = '0;
   logic [7:0]  awlen = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [31:0] wdata = '0;
   logic        wlast = 1'b0;
   logic        m_tvalid;
   logic        tready = 1'b0;
   logic [31:0] m_tdata;
   logic        m_tlast;
   logic [3:0]  m_tid;
   logic        len_err;
   logic [15:0] pkt_count;

   int          nerr = 0;
   int          nchk = 0;
   logic [15:0] pc_model = '0;
   logic [31:0] wd [256];
   string       cur_tag = "reset";
   vec_t        vecs [6];

   always #5 clk = ~clk;

   axi_write_packetizer dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .awvalid_i   (awvalid),
      .awready_o   (awready),
      .awaddr_i    (awaddr),
      .awid_i      (awid),
      .awlen_i     (awlen),
      .wvalid_i    (wvalid),
      .wready_o    (wready),
      .wdata_i     (wdata),
      .wlast_i     (wlast),
      .m_tvalid_o  (m_tvalid),
      .m_tready_i  (tready),
      .m_tdata_o   (m_tdata),
      .m_tlast_o   (m_tlast),
      .m_tid_o     (m_tid),
      .len_err_o   (len_err),
      .pkt_count_o (pkt_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s/%s: got %h, expected %h", cur_tag, name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s/%s: got %b, expected %b", cur_tag, name, act, exp);
      end
   endtask

   // Header from the field rules using plain arithmetic (2-bit X/Y fields).
   function automatic logic [31:0] model_hdr(logic [15:0] addr, logic [3:0] id, int len);
      int unsigned x, y;
      x = 32'(addr) / 16384;
      y = (32'(addr) / 4096) % 4;
      return 32'(x + y * 4 + RX * 16 + RY * 64 + 32'(id) * 256 + 32'(len) * 4096);
   endfunction

   function automatic int model_err(int len, int err_beat);
      int n = 0;
      for (int i = 0; i <= len; i++) begin
         if (((i == len) || (i == err_beat)) != (i == len)) n++;
      end
      return n;
   endfunction

   task automatic do_burst(input vec_t v);
      int          bound, cyc, beat, nflit, nlerr, k, ncmp;
      bit          got_aw, done, w_pend, prev_stall;
      logic [31:0] prev_data;
      logic [31:0] got_d [258];
      logic        got_l [258];
      logic [3:0]  got_t [258];

      for (int i = 0; i <= v.len; i++) wd[i] = (v.dmode == 1) ? 32'(i + 1) : $urandom;
      if (v.dmode == 2) wd[0] = 32'hDEADBEEF;
      bound = 8 * (v.len + 2) + 40;

      awvalid = 1'b1; awaddr = v.addr; awid = v.id; awlen = 8'(v.len);
      wvalid = 1'b0; wlast = 1'b0; tready = 1'b1;
      cyc = 0; got_aw = 1'b0;
      while (!got_aw && cyc < bound) begin
         @(negedge clk);
         chk1("idle_tvalid", m_tvalid, 1'b0);
         if (awready) got_aw = 1'b1;
         @(posedge clk); #1;
         cyc++;
      end
      awvalid = 1'b0;

      beat = 0; nflit = 0; nlerr = 0; k = 0;
      done = 1'b0; w_pend = 1'b0; prev_stall = 1'b0; prev_data = '0;
      while (!done && cyc < bound) begin
         case (v.tr_mode)
            0:       tready = 1'b1;
            1:       tready = (k % 2 == 1);
            default: tready = 1'($urandom_range(0, 1));
         endcase
         if (beat > v.len) wvalid = 1'b0;
         else if (!w_pend) wvalid = (v.wv_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
         wdata = (beat <= v.len) ? wd[beat] : '0;
         wlast = (beat == v.len) || (beat == v.err_beat);
         @(negedge clk);
         if (k == 0) chk1("hdr_latency", m_tvalid, 1'b1);
         chk1("busy_awready", awready, 1'b0);
         chk1("wready_mirror", wready, tready && (nflit > 0));
         if (prev_stall && nflit == 0) chk("hdr_hold", m_tdata, prev_data);
         if (len_err) nlerr++;
         if (m_tvalid && tready) begin
            if (nflit < 258) begin
               got_d[nflit] = m_tdata; got_l[nflit] = m_tlast; got_t[nflit] = m_tid;
            end
            nflit++;
            if (m_tlast || nflit >= v.len + 2) done = 1'b1;
         end
         w_pend = wvalid && !wready;
         if (wvalid && wready) beat++;
         prev_stall = m_tvalid && !tready;
         prev_data  = m_tdata;
         @(posedge clk); #1;
         cyc++; k++;
      end
      wvalid = 1'b0; wlast = 1'b0;

      if (!done) begin
         nerr++; nchk++;
         $display("FAIL %s/timeout: got %0d flits, expected %0d", cur_tag, nflit, v.len + 2);
         rst = 1'b1;
         repeat (2) @(posedge clk);
         #1 rst = 1'b0;
         pc_model = '0;
         return;
      end

      pc_model++;
      @(negedge clk);
      if (len_err) nlerr++;
      chk1("bubble_awready", awready, 1'b1);
      chk1("bubble_tvalid", m_tvalid, 1'b0);
      chk("pkt_count", 32'(pkt_count), 32'(pc_model));
      chk("flit_count", 32'(nflit), 32'(v.len + 2));
      chk("len_err_cycles", 32'(nlerr), 32'(v.exp_err));
      ncmp = (nflit < v.len + 2) ? nflit : v.len + 2;
      for (int i = 0; i < ncmp; i++) begin
         chk("flit_data", got_d[i], (i == 0) ? v.hdr : wd[i-1]);
         chk1("flit_last", got_l[i], (i == v.len + 1));
         chk("flit_tid", 32'(got_t[i]), 32'(v.id));
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t rv;
      int   beat;

      vecs[0] = '{16'hA000, 4'h3, 0,   0, 0, -1, 2, 32'h0000030A, 0};
      vecs[1] = '{16'h4000, 4'h5, 3,   1, 0, -1, 1, 32'h00003501, 0};
      vecs[2] = '{16'hF000, 4'hF, 255, 0, 0, -1, 0, 32'h000FFF0F, 0};
      vecs[3] = '{16'h1234, 4'h1, 1,   0, 0, 0,  0, 32'h00001104, 1};
      vecs[4] = '{16'h0FFF, 4'hA, 2,   2, 1, -1, 0, 32'h00002A00, 0};
      vecs[5] = '{16'h8800, 4'h6, 4,   2, 1, 2,  0, 32'h00004602, 1};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk1("rst_awready", awready, 1'b0);
      chk1("rst_wready", wready, 1'b0);
      chk1("rst_tvalid", m_tvalid, 1'b0);
      chk1("rst_tlast", m_tlast, 1'b0);
      chk("rst_tdata", m_tdata, 32'h0);
      chk("rst_tid", 32'(m_tid), 32'h0);
      chk1("rst_len_err", len_err, 1'b0);
      chk("rst_pkt_count", 32'(pkt_count), 32'h0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk1("post_rst_awready", awready, 1'b1);
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) begin
         cur_tag = $sformatf("vec%0d", i);
         do_burst(vecs[i]);
      end

      // Reset two beats into a four-beat burst.
      cur_tag = "mid_reset";
      awvalid = 1'b1; awaddr = 16'h5000; awid = 4'h9; awlen = 8'd3; tready = 1'b1;
      for (int c = 0; c < 10 && awvalid; c++) begin
         @(negedge clk);
         if (awready) begin
            @(posedge clk); #1 awvalid = 1'b0;
         end else begin
            @(posedge clk); #1;
         end
      end
      awvalid = 1'b0;
      beat = 0;
      for (int c = 0; c < 20 && beat < 2; c++) begin
         wvalid = 1'b1; wdata = 32'(beat + 100); wlast = 1'b0;
         @(negedge clk);
         if (wvalid && wready) beat++;
         @(posedge clk); #1;
      end
      chk("mid_beats", 32'(beat), 32'd2);
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk1("mr_tvalid", m_tvalid, 1'b0);
      chk1("mr_wready", wready, 1'b0);
      chk1("mr_awready", awready, 1'b0);
      chk1("mr_tlast", m_tlast, 1'b0);
      chk("mr_tdata", m_tdata, 32'h0);
      chk("mr_tid", 32'(m_tid), 32'h0);
      chk1("mr_len_err", len_err, 1'b0);
      chk("mr_pkt_count", 32'(pkt_count), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0; wvalid = 1'b0;
      pc_model = '0;
      @(posedge clk); #1;
      cur_tag = "post_reset";
      do_burst('{16'h6000, 4'h2, 0, 0, 0, -1, 0, model_hdr(16'h6000, 4'h2, 0), 0});

      for (int i = 0; i < 40; i++) begin
         cur_tag = $sformatf("rand%0d", i);
         rv.addr     = 16'($urandom);
         rv.id       = 4'($urandom);
         rv.len      = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 6);
         rv.tr_mode  = $urandom_range(0, 2);
         rv.wv_mode  = $urandom_range(0, 1);
         rv.err_beat = (rv.len > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(0, rv.len - 1)
                                                                 : -1;
         rv.dmode    = 0;
         rv.hdr      = model_hdr(rv.addr, rv.id, rv.len);
         rv.exp_err  = model_err(rv.len, rv.err_beat);
         do_burst(rv);
      end

      for (int i = 0; i < 200; i++) begin
         cur_tag = $sformatf("b2b%0d", i);
         rv.addr = 16'($urandom); rv.id = 4'($urandom); rv.len = 0;
         rv.tr_mode = 0; rv.wv_mode = 0; rv.err_beat = -1; rv.dmode = 0;
         rv.hdr = model_hdr(rv.addr, rv.id, 0);
         rv.exp_err = 0;
         do_burst(rv);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
